// File: rtl/e203_eai_csr_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : e203_eai_csr_req_ctrl
// Purpose  : Single-outstanding request controller for the extended-CSR port,
//            with an optional abort watchdog (E203_EAI_CSR_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module e203_eai_csr_req_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic [11:0] csr_req_addr,
    input  logic        csr_req_wr,
    input  logic [31:0] csr_req_wdata,

    output logic        csr_rsp_valid,
    input  logic        csr_rsp_ready,
    output logic [31:0] csr_rsp_rdata,
    output logic        csr_rsp_err,

    output logic        eai_csr_valid,
    input  logic        eai_csr_ready,
    output logic [31:0] eai_csr_addr,
    output logic        eai_csr_wr,
    output logic [31:0] eai_csr_wdata,
    input  logic [31:0] eai_csr_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_addr;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_hit;
    logic        w_expire;

    assign w_accept = csr_req_valid & (r_state == ST_IDLE);
    assign w_hit    = eai_csr_ready & (r_state == ST_REQ);

`ifdef E203_EAI_CSR_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;

    // Ready in the expiry cycle takes priority, so expiry requires ~ready.
    assign w_expire = (r_state == ST_REQ) & ~eai_csr_ready & (r_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= 8'd0;
            end else if ((r_state == ST_REQ) && !eai_csr_ready) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_hit) begin
                r_err <= 1'b0;
            end else if (w_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign csr_rsp_err = r_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^c_TO_LAST;
    assign w_expire     = 1'b0;
    assign csr_rsp_err  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (csr_req_valid)            w_state_nxt = ST_REQ;
            ST_REQ:  if (eai_csr_ready || w_expire) w_state_nxt = ST_RSP;
            ST_RSP:  if (csr_rsp_ready)            w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= 12'd0;
            r_wr    <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= csr_req_addr;
                r_wr    <= csr_req_wr;
                r_wdata <= csr_req_wdata;
            end
            // Writes capture the target's read-back value as well.
            if (w_hit) begin
                r_rdata <= eai_csr_rdata;
            end else if (w_expire) begin
                r_rdata <= 32'd0;
            end
        end
    end

    assign csr_req_ready = (r_state == ST_IDLE);
    assign eai_csr_valid = (r_state == ST_REQ);
    assign csr_rsp_valid = (r_state == ST_RSP);
    assign eai_csr_addr  = {20'd0, r_addr};
    assign eai_csr_wr    = r_wr;
    assign eai_csr_wdata = r_wdata;
    assign csr_rsp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_e203_eai_csr_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_eai_csr_req_ctrl
// Purpose  : Directed self-checking bench for e203_eai_csr_req_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_eai_csr_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic [11:0] csr_req_addr;
    logic        csr_req_wr;
    logic [31:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_err;
    logic        eai_csr_valid;
    logic        eai_csr_ready;
    logic [31:0] eai_csr_addr;
    logic        eai_csr_wr;
    logic [31:0] eai_csr_wdata;
    logic [31:0] eai_csr_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e203_eai_csr_req_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_req_valid (csr_req_valid),
        .csr_req_ready (csr_req_ready),
        .csr_req_addr  (csr_req_addr),
        .csr_req_wr    (csr_req_wr),
        .csr_req_wdata (csr_req_wdata),
        .csr_rsp_valid (csr_rsp_valid),
        .csr_rsp_ready (csr_rsp_ready),
        .csr_rsp_rdata (csr_rsp_rdata),
        .csr_rsp_err   (csr_rsp_err),
        .eai_csr_valid (eai_csr_valid),
        .eai_csr_ready (eai_csr_ready),
        .eai_csr_addr  (eai_csr_addr),
        .eai_csr_wr    (eai_csr_wr),
        .eai_csr_wdata (eai_csr_wdata),
        .eai_csr_rdata (eai_csr_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        csr_req_valid = 1'b0;
        csr_req_addr  = 12'h000;
        csr_req_wr    = 1'b0;
        csr_req_wdata = 32'h0;
        csr_rsp_ready = 1'b0;
        eai_csr_ready = 1'b0;
        eai_csr_rdata = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_req_ready", 32'(csr_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", csr_rsp_rdata, 32'h0);
        chk("rst_rsp_err",   32'(csr_rsp_err), 32'd0);
        chk("rst_eai_valid", 32'(eai_csr_valid), 32'd0);
        chk("rst_eai_addr",  eai_csr_addr, 32'h0);
        chk("rst_eai_wr",    32'(eai_csr_wr), 32'd0);
        chk("rst_eai_wdata", eai_csr_wdata, 32'h0);

        // Read, target ready immediately: cycle 0 accept, 1 request, 2 response.
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h7C0;
        csr_req_wr    = 1'b0;
        eai_csr_ready = 1'b1;
        eai_csr_rdata = 32'hDEADBEEF;
        tick();
        csr_req_valid = 1'b0;
        chk("rd_c1_eai_valid", 32'(eai_csr_valid), 32'd1);
        chk("rd_c1_eai_addr",  eai_csr_addr, 32'h000007C0);
        chk("rd_c1_eai_wr",    32'(eai_csr_wr), 32'd0);
        chk("rd_c1_req_ready", 32'(csr_req_ready), 32'd0);
        chk("rd_c1_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        tick();
        eai_csr_ready = 1'b0;
        eai_csr_rdata = 32'h0BADF00D;
        chk("rd_c2_rsp_valid", 32'(csr_rsp_valid), 32'd1);
        chk("rd_c2_rsp_rdata", csr_rsp_rdata, 32'hDEADBEEF);
        chk("rd_c2_rsp_err",   32'(csr_rsp_err), 32'd0);
        chk("rd_c2_eai_valid", 32'(eai_csr_valid), 32'd0);
        csr_rsp_ready = 1'b1;
        tick();
        csr_rsp_ready = 1'b0;
        chk("rd_done_req_ready", 32'(csr_req_ready), 32'd1);
        chk("rd_done_rsp_valid", 32'(csr_rsp_valid), 32'd0);

        // Write, target ready on the 6th request cycle; inputs change after accept.
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h7C1;
        csr_req_wr    = 1'b1;
        csr_req_wdata = 32'h12345678;
        tick();
        csr_req_valid = 1'b0;
        csr_req_addr  = 12'h000;
        csr_req_wr    = 1'b0;
        csr_req_wdata = 32'h0;
        for (int i = 1; i <= 6; i++) begin
            chk("wr_eai_valid", 32'(eai_csr_valid), 32'd1);
            chk("wr_eai_wr",    32'(eai_csr_wr), 32'd1);
            chk("wr_eai_wdata", eai_csr_wdata, 32'h12345678);
            chk("wr_eai_addr",  eai_csr_addr, 32'h000007C1);
            chk("wr_no_rsp",    32'(csr_rsp_valid), 32'd0);
            if (i == 6) begin
                eai_csr_ready = 1'b1;
                eai_csr_rdata = 32'hA5A50001;
            end
            tick();
        end
        eai_csr_ready = 1'b0;
        eai_csr_rdata = 32'h0;
        chk("wr_rsp_valid", 32'(csr_rsp_valid), 32'd1);
        chk("wr_rsp_rdata", csr_rsp_rdata, 32'hA5A50001);
        chk("wr_rsp_err",   32'(csr_rsp_err), 32'd0);
        chk("wr_eai_drop",  32'(eai_csr_valid), 32'd0);

        // Response backpressure with a competing request waiting.
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h7C2;
        csr_req_wr    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 32'(csr_rsp_valid), 32'd1);
            chk("bp_rsp_rdata", csr_rsp_rdata, 32'hA5A50001);
            chk("bp_req_ready", 32'(csr_req_ready), 32'd0);
            chk("bp_eai_valid", 32'(eai_csr_valid), 32'd0);
            tick();
        end
        csr_rsp_ready = 1'b1;
        tick();
        csr_rsp_ready = 1'b0;
        chk("bp_hs_req_ready", 32'(csr_req_ready), 32'd1);
        chk("bp_hs_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        chk("bp_hs_eai_valid", 32'(eai_csr_valid), 32'd0);
        eai_csr_ready = 1'b1;
        eai_csr_rdata = 32'h00000C02;
        tick();
        csr_req_valid = 1'b0;
        chk("bp_next_eai_valid", 32'(eai_csr_valid), 32'd1);
        chk("bp_next_eai_addr",  eai_csr_addr, 32'h000007C2);
        tick();
        eai_csr_ready = 1'b0;
        chk("bp_next_rsp_rdata", csr_rsp_rdata, 32'h00000C02);
        csr_rsp_ready = 1'b1;
        tick();
        csr_rsp_ready = 1'b0;

`ifdef E203_EAI_CSR_TIMEOUT_EN
        // Target never ready: 4 request cycles, then an error response.
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h7C3;
        tick();
        csr_req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("to_eai_valid", 32'(eai_csr_valid), 32'd1);
            tick();
        end
        chk("to_eai_drop",  32'(eai_csr_valid), 32'd0);
        chk("to_rsp_valid", 32'(csr_rsp_valid), 32'd1);
        chk("to_rsp_err",   32'(csr_rsp_err), 32'd1);
        chk("to_rsp_rdata", csr_rsp_rdata, 32'h0);
        csr_rsp_ready = 1'b1;
        tick();
        csr_rsp_ready = 1'b0;

        // Ready arriving on the expiry cycle wins.
        csr_req_valid = 1'b1;
        tick();
        csr_req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("tor_eai_valid", 32'(eai_csr_valid), 32'd1);
            if (i == 4) begin
                eai_csr_ready = 1'b1;
                eai_csr_rdata = 32'h00004444;
            end
            tick();
        end
        eai_csr_ready = 1'b0;
        chk("tor_rsp_valid", 32'(csr_rsp_valid), 32'd1);
        chk("tor_rsp_err",   32'(csr_rsp_err), 32'd0);
        chk("tor_rsp_rdata", csr_rsp_rdata, 32'h00004444);
        csr_rsp_ready = 1'b1;
        tick();
        csr_rsp_ready = 1'b0;
`else
        // Without the watchdog the request waits indefinitely.
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h7C3;
        tick();
        csr_req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("nto_eai_valid", 32'(eai_csr_valid), 32'd1);
            chk("nto_no_rsp",    32'(csr_rsp_valid), 32'd0);
            tick();
        end
        eai_csr_ready = 1'b1;
        eai_csr_rdata = 32'h00004444;
        tick();
        eai_csr_ready = 1'b0;
        chk("nto_rsp_valid", 32'(csr_rsp_valid), 32'd1);
        chk("nto_rsp_err",   32'(csr_rsp_err), 32'd0);
        chk("nto_rsp_rdata", csr_rsp_rdata, 32'h00004444);
        csr_rsp_ready = 1'b1;
        tick();
        csr_rsp_ready = 1'b0;
`endif

        // Reset while a request is outstanding.
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h7C4;
        tick();
        csr_req_valid = 1'b0;
        chk("rq_pre_eai_valid", 32'(eai_csr_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rq_eai_valid", 32'(eai_csr_valid), 32'd0);
        chk("rq_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        chk("rq_req_ready", 32'(csr_req_ready), 32'd1);
        chk("rq_eai_addr",  eai_csr_addr, 32'h0);
        eai_csr_ready = 1'b1;
        eai_csr_rdata = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rq_no_stale", 32'(csr_rsp_valid), 32'd0);
        end
        eai_csr_ready = 1'b0;

        // Reset while a response is pending.
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h7C5;
        eai_csr_ready = 1'b1;
        eai_csr_rdata = 32'h55AA55AA;
        tick();
        csr_req_valid = 1'b0;
        tick();
        eai_csr_ready = 1'b0;
        chk("rs_pre_rsp_valid", 32'(csr_rsp_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        chk("rs_rsp_rdata", csr_rsp_rdata, 32'h0);
        chk("rs_req_ready", 32'(csr_req_ready), 32'd1);
        chk("rs_eai_valid", 32'(eai_csr_valid), 32'd0);
        csr_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_stale", 32'(csr_rsp_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
